// File: rtl/ber_lane_counter.sv
// rtl/ber_lane_counter.sv - per-lane PRBS delay search and saturating BER bit/error accumulator
// Optional BER_RESYNC_EN: windowed loss-of-lock detection in COUNT with automatic re-search.
module ber_lane_counter #(
    parameter int SR_LEN             = 511,
    parameter int SYNC_WIN           = 511,
    parameter int RESYNC_THR         = 64,
    parameter int NBT_COUNT_BITS_ERR = 64
) (
    input  logic                          clk,
    input  logic                          i_reset,
    input  logic                          i_valid,
    input  logic                          i_ref_bit,
    input  logic                          i_rx_bit,
    output logic [NBT_COUNT_BITS_ERR-1:0] o_accum_bit,
    output logic [NBT_COUNT_BITS_ERR-1:0] o_accum_err,
    output logic                          o_synced,
    output logic [$clog2(SR_LEN)-1:0]     o_delay
);

    localparam int DW = $clog2(SR_LEN);
    localparam int FW = $clog2(SR_LEN + 1);
    localparam int WW = $clog2(SYNC_WIN + 1);
    localparam int CW = NBT_COUNT_BITS_ERR;

`ifdef BER_RESYNC_EN
    localparam bit RESYNC_EN = 1'b1;
`else
    localparam bit RESYNC_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_FILL   = 2'd0,
        S_SEARCH = 2'd1,
        S_COUNT  = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [SR_LEN-1:0]   r_ref_sr;
    logic [FW-1:0]       fill_cnt;
    logic [WW-1:0]       win_cnt;
    logic [WW-1:0]       win_err;
    logic [WW-1:0]       min_err;
    logic [DW-1:0]       cand;
    logic [DW-1:0]       best;
    logic [DW-1:0]       delay_q;
    logic [CW-1:0]       accum_bit_q;
    logic [CW-1:0]       accum_err_q;

    logic                e_cand;
    logic                e_lock;
    logic                e_win;
    logic                fill_done;
    logic                win_last;
    logic                cand_last;
    logic [WW-1:0]       win_sum;
    logic                better;
    logic [DW-1:0]       best_sel;
    logic                resync_hit;

    always_comb begin
        e_cand     = i_rx_bit ^ r_ref_sr[cand];
        e_lock     = i_rx_bit ^ r_ref_sr[delay_q];
        e_win      = (state_q == S_COUNT) ? e_lock : e_cand;
        fill_done  = (fill_cnt == FW'(SR_LEN - 1));
        win_last   = (win_cnt == WW'(SYNC_WIN - 1));
        cand_last  = (cand == DW'(SR_LEN - 1));
        // The window's final sample is folded into the sum it is judged by.
        win_sum    = win_err + WW'(e_win);
        better     = (win_sum < min_err);
        best_sel   = better ? cand : best;
        resync_hit = RESYNC_EN && win_last && (32'(win_sum) > 32'(RESYNC_THR));
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q <= S_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (i_valid) begin
            case (state_q)
                S_FILL:   if (fill_done) state_d = S_SEARCH;
                S_SEARCH: if (win_last && cand_last) state_d = S_COUNT;
                S_COUNT:  if (resync_hit) state_d = S_SEARCH;
                default:  state_d = S_FILL;
            endcase
        end
    end

    always_comb begin
        o_synced    = (state_q == S_COUNT);
        o_delay     = delay_q;
        o_accum_bit = accum_bit_q;
        o_accum_err = accum_err_q;
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_ref_sr    <= '0;
            fill_cnt    <= '0;
            win_cnt     <= '0;
            win_err     <= '0;
            min_err     <= '0;
            cand        <= '0;
            best        <= '0;
            delay_q     <= '0;
            accum_bit_q <= '0;
            accum_err_q <= '0;
        end else if (i_valid) begin
            r_ref_sr <= {r_ref_sr[SR_LEN-2:0], i_ref_bit};
            case (state_q)
                S_FILL: begin
                    fill_cnt <= fill_cnt + FW'(1);
                    if (fill_done) begin
                        fill_cnt <= '0;
                        cand     <= '0;
                        best     <= '0;
                        min_err  <= '1;
                        win_cnt  <= '0;
                        win_err  <= '0;
                    end
                end
                S_SEARCH: begin
                    if (win_last) begin
                        win_cnt <= '0;
                        win_err <= '0;
                        if (better) begin
                            min_err <= win_sum;
                            best    <= cand;
                        end
                        if (cand_last) begin
                            delay_q <= best_sel;
                            cand    <= '0;
                        end else begin
                            cand <= cand + DW'(1);
                        end
                    end else begin
                        win_cnt <= win_cnt + WW'(1);
                        win_err <= win_sum;
                    end
                end
                S_COUNT: begin
                    if (accum_bit_q != '1) accum_bit_q <= accum_bit_q + CW'(1);
                    if (e_lock && (accum_err_q != '1)) accum_err_q <= accum_err_q + CW'(1);
`ifdef BER_RESYNC_EN
                    if (win_last) begin
                        win_cnt <= '0;
                        win_err <= '0;
                        if (resync_hit) begin
                            cand    <= '0;
                            best    <= '0;
                            min_err <= '1;
                        end
                    end else begin
                        win_cnt <= win_cnt + WW'(1);
                        win_err <= win_sum;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ber_lane_counter.sv
// tb/tb_ber_lane_counter.sv - directed table-driven bench for ber_lane_counter
module tb_ber_lane_counter;

    localparam int SR_LEN   = 8;
    localparam int SYNC_WIN = 16;
    localparam int LOCK_N   = SR_LEN + SR_LEN * SYNC_WIN;

    logic        clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_ref_bit = 1'b0;
    logic        i_rx_bit = 1'b0;
    logic [63:0] o_accum_bit;
    logic [63:0] o_accum_err;
    logic        o_synced;
    logic [2:0]  o_delay;

    int n_tests = 0;
    int n_fail  = 0;
    int gap_bad = 0;
    logic [8:0]  lfsr = 9'h1FF;
    logic [15:0] hist = '0;

    always #5 clk = ~clk;

    ber_lane_counter #(
        .SR_LEN(SR_LEN), .SYNC_WIN(SYNC_WIN), .RESYNC_THR(4), .NBT_COUNT_BITS_ERR(64)
    ) dut (
        .clk(clk), .i_reset(i_reset), .i_valid(i_valid), .i_ref_bit(i_ref_bit),
        .i_rx_bit(i_rx_bit), .o_accum_bit(o_accum_bit), .o_accum_err(o_accum_err),
        .o_synced(o_synced), .o_delay(o_delay)
    );

    typedef struct {
        int     tap;
        int     period;
        int     flip_every;
        int     n_count;
        int     exp_delay;
        longint exp_bit;
        longint exp_err;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // rx is the reference as seen tap+1 samples ago, optionally inverted.
    task automatic sample(input int tap, input bit flip);
        logic r;
        r         = lfsr[8];
        i_valid   = 1'b1;
        i_ref_bit = r;
        i_rx_bit  = hist[tap] ^ flip;
        tick();
        i_valid = 1'b0;
        hist    = {hist[14:0], r};
        lfsr    = {lfsr[7:0], lfsr[8] ^ lfsr[4]};
    endtask

    task automatic gap(input int n);
        logic [63:0] b, e;
        logic        s;
        logic [2:0]  d;
        for (int i = 0; i < n; i++) begin
            b = o_accum_bit; e = o_accum_err; s = o_synced; d = o_delay;
            i_valid   = 1'b0;
            i_ref_bit = 1'($urandom);
            i_rx_bit  = 1'($urandom);
            tick();
            if (b !== o_accum_bit || e !== o_accum_err || s !== o_synced || d !== o_delay)
                gap_bad++;
        end
    endtask

    task automatic vsample(input int tap, input bit flip, input int period);
        sample(tap, flip);
        gap(period - 1);
    endtask

    task automatic do_reset();
        i_reset   = 1'b1;
        i_valid   = 1'($urandom);
        i_ref_bit = 1'($urandom);
        i_rx_bit  = 1'($urandom);
        tick();
        tick();
        i_reset = 1'b0;
        i_valid = 1'b0;
        lfsr    = 9'h1FF;
        hist    = '0;
    endtask

    task automatic run_to_lock(input int tap, input int period, output int cnt);
        cnt = 0;
        while (!o_synced && cnt < 400) begin
            vsample(tap, 1'b0, period);
            cnt++;
        end
    endtask

    vec_t vecs[6];

    initial begin
        int     cnt;
        longint exp_err;
        longint bit_drop, err_drop;
        int     dropped;

        vecs[0] = '{tap: 5, period: 1, flip_every: 0,  n_count: 100,  exp_delay: 5, exp_bit: 100,  exp_err: 0};
        vecs[1] = '{tap: 5, period: 1, flip_every: 10, n_count: 1000, exp_delay: 5, exp_bit: 1000, exp_err: 100};
        vecs[2] = '{tap: 5, period: 4, flip_every: 0,  n_count: 100,  exp_delay: 5, exp_bit: 100,  exp_err: 0};
        vecs[3] = '{tap: 0, period: 1, flip_every: 0,  n_count: 20,   exp_delay: 0, exp_bit: 20,   exp_err: 0};
        vecs[4] = '{tap: 7, period: 2, flip_every: 0,  n_count: 30,   exp_delay: 7, exp_bit: 30,   exp_err: 0};
        vecs[5] = '{tap: 2, period: 1, flip_every: 5,  n_count: 40,   exp_delay: 2, exp_bit: 40,   exp_err: 8};

        // Reset with random inputs: outputs cleared after the first edge.
        i_reset = 1'b1;
        i_valid = 1'($urandom); i_ref_bit = 1'($urandom); i_rx_bit = 1'($urandom);
        tick();
        check("rst1_synced", o_synced, 0);
        check("rst1_bit", o_accum_bit, 0);
        check("rst1_err", o_accum_err, 0);
        check("rst1_delay", o_delay, 0);
        i_valid = 1'($urandom); i_ref_bit = 1'($urandom); i_rx_bit = 1'($urandom);
        tick();
        check("rst2_synced", o_synced, 0);
        check("rst2_bit", o_accum_bit, 0);
        i_reset = 1'b0;

        for (int v = 0; v < 6; v++) begin
            do_reset();
            gap_bad = 0;
            run_to_lock(vecs[v].tap, vecs[v].period, cnt);
            check($sformatf("v%0d_lock_samples", v), cnt, LOCK_N);
            check($sformatf("v%0d_delay", v), o_delay, vecs[v].exp_delay);
            check($sformatf("v%0d_bit_at_lock", v), o_accum_bit, 0);
            for (int k = 0; k < vecs[v].n_count; k++)
                vsample(vecs[v].tap,
                        (vecs[v].flip_every != 0) && (k % vecs[v].flip_every == vecs[v].flip_every - 1),
                        vecs[v].period);
            check($sformatf("v%0d_accum_bit", v), o_accum_bit, vecs[v].exp_bit);
            check($sformatf("v%0d_accum_err", v), o_accum_err, vecs[v].exp_err);
            if (vecs[v].period > 1)
                check($sformatf("v%0d_gap_stable", v), gap_bad, 0);
        end

        // Reset mid-COUNT, then full re-lock.
        do_reset();
        run_to_lock(5, 1, cnt);
        for (int k = 0; k < 50; k++) sample(5, 1'b0);
        check("midcnt_bit50", o_accum_bit, 50);
        i_reset = 1'b1; i_valid = 1'b1;
        tick();
        i_reset = 1'b0; i_valid = 1'b0;
        check("midcnt_rst_synced", o_synced, 0);
        check("midcnt_rst_bit", o_accum_bit, 0);
        check("midcnt_rst_delay", o_delay, 0);
        run_to_lock(5, 1, cnt);
        check("midcnt_relock", cnt, LOCK_N);
        check("midcnt_relock_delay", o_delay, 5);

        // Reset mid-SEARCH restarts the full fill + search.
        do_reset();
        for (int k = 0; k < 60; k++) sample(3, 1'b0);
        do_reset();
        run_to_lock(3, 1, cnt);
        check("midsearch_relock", cnt, LOCK_N);
        check("midsearch_delay", o_delay, 3);

        // Channel delay moves from tap 5 to tap 2 while counting.
        do_reset();
        run_to_lock(5, 1, cnt);
        for (int k = 0; k < 20; k++) sample(5, 1'b0);
`ifndef BER_RESYNC_EN
        exp_err = 0;
        dropped = 0;
        for (int k = 0; k < 64; k++) begin
            if (hist[2] != hist[5]) exp_err++;
            sample(2, 1'b0);
            if (!o_synced) dropped++;
        end
        check("shift_no_drop", dropped, 0);
        check("shift_delay_held", o_delay, 5);
        check("shift_bit", o_accum_bit, 84);
        check("shift_err", o_accum_err, exp_err);
        check("shift_err_nonzero", longint'(o_accum_err != 0), 1);
`else
        cnt = 0;
        while (o_synced && cnt < 64) begin sample(2, 1'b0); cnt++; end
        check("resync_dropped", o_synced, 0);
        bit_drop = o_accum_bit;
        err_drop = o_accum_err;
        run_to_lock(2, 1, cnt);
        check("resync_relock_bit_held", o_accum_bit, bit_drop);
        check("resync_delay", o_delay, 2);
        for (int k = 0; k < 10; k++) sample(2, 1'b0);
        check("resync_bit_resume", o_accum_bit, bit_drop + 10);
        check("resync_err_clean", o_accum_err, err_drop);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
